// File: rtl/spi_flash_ip.sv
// Register-mapped SPI flash master: one mode-0 transfer of command, 24-bit
// address and up to four data bytes, read or written depending on the command.
module spi_flash_ip #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        spi_cs_n,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [7:0] READ_CMD = 8'h03;

  state_t           r_state;
  logic [7:0]       r_cmd;
  logic [23:0]      r_faddr;
  logic [2:0]       r_len;
  logic [31:0]      r_txData;
  logic [31:0]      r_rxData;
  logic [31:0]      r_rdata;
  logic             r_done;
  logic             r_pending;
  logic             r_isRead;
  logic [63:0]      r_shift;
  logic [6:0]       r_totalBits;
  logic [6:0]       r_bitCnt;
  logic [DIVW-1:0]  r_divCnt;
  logic             r_csN;
  logic             r_sclk;
  logic             r_mosi;

  logic [2:0]       w_lenEff;
  logic [31:0]      w_txAligned;
  logic             w_busy;
  logic             w_start;
  logic             w_tick;
  logic             w_lastBit;

  // Lengths 5-7 behave as 4; transmit data is left-aligned so the shift
  // register always emits command, address, then data from bit 63.
  assign w_lenEff    = (r_len > 3'd4) ? 3'd4 : r_len;
  assign w_txAligned = r_txData << (6'd32 - {w_lenEff, 3'b000});
  assign w_busy      = (r_state != IDLE);
  assign w_start     = wr_en && (addr == 8'h0C) && wdata[0] && !w_busy && !r_pending;
  assign w_tick      = (r_divCnt == DIV_LAST);
  assign w_lastBit   = (r_bitCnt == (r_totalBits - 7'd1));

  assign rdata    = r_rdata;
  assign spi_cs_n = r_csN;
  assign spi_clk  = r_sclk;
  assign spi_mosi = r_mosi;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cmd       <= '0;
      r_faddr     <= '0;
      r_len       <= '0;
      r_txData    <= '0;
      r_rxData    <= '0;
      r_rdata     <= '0;
      r_done      <= 1'b0;
      r_pending   <= 1'b0;
      r_isRead    <= 1'b0;
      r_shift     <= '0;
      r_totalBits <= '0;
      r_bitCnt    <= '0;
      r_divCnt    <= '0;
      r_csN       <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          8'h00:   r_cmd    <= wdata[7:0];
          8'h04:   r_faddr  <= wdata[23:0];
          8'h08:   r_len    <= wdata[2:0];
          8'h14:   r_txData <= wdata;
          default: ;
        endcase
      end

      if (rd_en) begin
        case (addr)
          8'h00:   r_rdata <= {24'b0, r_cmd};
          8'h04:   r_rdata <= {8'b0, r_faddr};
          8'h08:   r_rdata <= {29'b0, r_len};
          8'h0C:   r_rdata <= {30'b0, r_done, w_busy};
          8'h10:   r_rdata <= r_rxData;
          8'h14:   r_rdata <= r_txData;
          default: r_rdata <= '0;
        endcase
      end

      // Fields are captured here so later register writes cannot disturb the transfer.
      if (w_start) begin
        r_pending   <= 1'b1;
        r_isRead    <= (r_cmd == READ_CMD);
        r_shift     <= {r_cmd, r_faddr, (r_cmd == READ_CMD) ? 32'd0 : w_txAligned};
        r_totalBits <= 7'd32 + {1'b0, w_lenEff, 3'b000};
        r_done      <= 1'b0;
        if (r_cmd == READ_CMD)
          r_rxData <= '0;
      end

      if (r_pending) begin
        r_pending <= 1'b0;
        r_state   <= CMD;
        r_csN     <= 1'b0;
        r_sclk    <= 1'b0;
        r_mosi    <= r_shift[63];
        r_divCnt  <= '0;
        r_bitCnt  <= '0;
      end else if (w_busy) begin
        if (!w_tick) begin
          r_divCnt <= r_divCnt + DIVW'(1);
        end else begin
          r_divCnt <= '0;
          if (!r_sclk) begin
            r_sclk <= 1'b1;
            if (r_isRead && (r_state == DATA))
              r_rxData <= {r_rxData[30:0], spi_miso};
          end else begin
            r_sclk <= 1'b0;
            if (w_lastBit) begin
              r_state <= IDLE;
              r_csN   <= 1'b1;
              r_mosi  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 7'd1;
              r_shift  <= {r_shift[62:0], 1'b0};
              r_mosi   <= r_shift[62];
              if (r_bitCnt == 7'd7)
                r_state <= ADDR;
              else if (r_bitCnt == 7'd31)
                r_state <= DATA;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_ip.sv
// Directed bench for spi_flash_ip: a flash model on the SPI pins captures MOSI
// bytes and feeds MISO, and a queue of expected bytes is matched against them.
module tb_spi_flash_ip;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  int passCount = 0;
  int failCount = 0;
  int checkCount = 0;

  logic [7:0]  expQ[$];
  logic [7:0]  gotBytes[256];
  int          gotCount = 0;
  int          gotPtr = 0;
  int          pulseCount = 0;
  int          csLowCount = 0;
  logic [31:0] misoWord = '0;

  int          bitIdx = 0;
  int          misoIdx = 0;
  logic [7:0]  shiftByte = '0;

  spi_flash_ip #(.CLK_DIV(1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (spi_cs_n === 1'b0) csLowCount++;

  // Flash model: captures MOSI on each rising SPI clock and presents the next MISO bit.
  always @(posedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      bitIdx = 0;
      misoIdx = 0;
      spi_miso = 1'b0;
    end else begin
      shiftByte = {shiftByte[6:0], spi_mosi};
      bitIdx++;
      misoIdx++;
      pulseCount++;
      spi_miso = (misoIdx >= 32 && misoIdx < 64) ? misoWord[63 - misoIdx] : 1'b0;
      if (bitIdx == 8) begin
        bitIdx = 0;
        gotBytes[gotCount % 256] = shiftByte;
        gotCount++;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic regWrite(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; wdata = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic regRead(input logic [7:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    v = rdata;
  endtask

  task automatic readCheck(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] v;
    regRead(a, v);
    checkOutput(tag, v, exp);
  endtask

  // Programs the registers and queues the MOSI bytes the flash should see.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] fa,
                               input logic [2:0] len, input logic [31:0] tx);
    int n;
    regWrite(8'h00, {24'b0, cmd});
    regWrite(8'h04, {8'b0, fa});
    regWrite(8'h08, {29'b0, len});
    regWrite(8'h14, tx);
    n = (len > 3'd4) ? 4 : int'(len);
    expQ.push_back(cmd);
    expQ.push_back(fa[23:16]);
    expQ.push_back(fa[15:8]);
    expQ.push_back(fa[7:0]);
    for (int i = 0; i < n; i++)
      expQ.push_back((cmd == 8'h03) ? 8'h00 : tx[8*(n-1-i) +: 8]);
  endtask

  task automatic waitDone(input string tag);
    int n = 0;
    while (spi_cs_n !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    while (spi_cs_n !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    checkOutput({tag, " completes"}, (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic checkBytes(input string tag);
    logic [7:0] exp;
    logic [7:0] got;
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      if (gotPtr < gotCount) begin
        got = gotBytes[gotPtr % 256];
        gotPtr++;
      end else begin
        got = 8'hxx;
      end
      checkOutput({tag, " mosi byte"}, {24'b0, got}, {24'b0, exp});
    end
    checkOutput({tag, " extra bytes"}, gotCount - gotPtr, 0);
    gotPtr = gotCount;
  endtask

  initial begin
    int p0;
    int c0;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset cs_n", {31'b0, spi_cs_n}, 32'd1);
    checkOutput("reset spi_clk", {31'b0, spi_clk}, 32'd0);
    checkOutput("reset mosi", {31'b0, spi_mosi}, 32'd0);
    checkOutput("reset rdata", rdata, 32'd0);
    for (int a = 0; a <= 8'h14; a += 4)
      readCheck($sformatf("reset reg 0x%0h", a), 8'(a), 32'd0);

    regWrite(8'h00, 32'h03);
    regWrite(8'h04, 32'h000010);
    regWrite(8'h08, 32'h4);
    regWrite(8'h14, 32'hAA);
    readCheck("rb CMD", 8'h00, 32'h03);
    readCheck("rb FADDR", 8'h04, 32'h10);
    readCheck("rb LEN", 8'h08, 32'h4);
    readCheck("rb TXDATA", 8'h14, 32'hAA);
    regWrite(8'h18, 32'hFFFF_FFFF);
    readCheck("unmapped reg", 8'h18, 32'd0);

    // Read transfer with the flash returning DEADBEEF.
    misoWord = 32'hDEAD_BEEF;
    applyStimulus(8'h03, 24'h000010, 3'd4, 32'hAA);
    p0 = pulseCount; c0 = csLowCount;
    regWrite(8'h0C, 32'h1);
    waitDone("read4");
    checkOutput("read4 cs low cycles", csLowCount - c0, 128);
    checkOutput("read4 pulses", pulseCount - p0, 64);
    checkBytes("read4");
    readCheck("read4 RXDATA", 8'h10, 32'hDEAD_BEEF);
    readCheck("read4 CTRL", 8'h0C, 32'h2);

    // Write transfer, also checking the one-cycle start latency.
    applyStimulus(8'h02, 24'h123456, 3'd1, 32'hAA);
    p0 = pulseCount; c0 = csLowCount;
    regWrite(8'h0C, 32'h1);
    checkOutput("start latency cs_n", {31'b0, spi_cs_n}, 32'd1);
    @(negedge clk);
    checkOutput("start cs_n low", {31'b0, spi_cs_n}, 32'd0);
    checkOutput("start first mosi", {31'b0, spi_mosi}, 32'd0);
    waitDone("write1");
    checkOutput("write1 cs low cycles", csLowCount - c0, 80);
    checkOutput("write1 pulses", pulseCount - p0, 40);
    checkBytes("write1");
    readCheck("write1 RXDATA kept", 8'h10, 32'hDEAD_BEEF);

    // Restart and register writes while busy must not disturb the transfer.
    applyStimulus(8'h02, 24'h123456, 3'd1, 32'hAA);
    p0 = pulseCount; c0 = csLowCount;
    regWrite(8'h0C, 32'h1);
    repeat (6) @(negedge clk);
    readCheck("busy CTRL", 8'h0C, 32'h1);
    regWrite(8'h0C, 32'h1);
    regWrite(8'h00, 32'h03);
    waitDone("busy restart");
    checkOutput("busy restart pulses", pulseCount - p0, 40);
    checkOutput("busy restart cs low", csLowCount - c0, 80);
    checkBytes("busy restart");
    readCheck("busy CMD write kept", 8'h00, 32'h03);

    // LEN=7 behaves as 4, then a back-to-back LEN=0 transfer.
    applyStimulus(8'h02, 24'h000000, 3'd7, 32'h1122_3344);
    readCheck("rb LEN7", 8'h08, 32'h7);
    p0 = pulseCount;
    regWrite(8'h0C, 32'h1);
    waitDone("len7");
    checkOutput("len7 pulses", pulseCount - p0, 64);
    checkBytes("len7");
    applyStimulus(8'h06, 24'hABCDEF, 3'd0, 32'h0);
    p0 = pulseCount; c0 = csLowCount;
    regWrite(8'h0C, 32'h1);
    waitDone("len0");
    checkOutput("len0 pulses", pulseCount - p0, 32);
    checkOutput("len0 cs low cycles", csLowCount - c0, 64);
    checkBytes("len0");

    // Reset in the middle of a transfer.
    p0 = pulseCount;
    regWrite(8'h0C, 32'h1);
    n = 0;
    while (pulseCount - p0 < 20 && n < 3000) begin @(negedge clk); n++; end
    checkOutput("reach pulse 20", (n >= 3000) ? 32'd1 : 32'd0, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset cs_n", {31'b0, spi_cs_n}, 32'd1);
    checkOutput("midreset spi_clk", {31'b0, spi_clk}, 32'd0);
    checkOutput("midreset mosi", {31'b0, spi_mosi}, 32'd0);
    rst = 1'b0;
    gotPtr = gotCount;
    readCheck("midreset CMD", 8'h00, 32'd0);
    readCheck("midreset FADDR", 8'h04, 32'd0);
    readCheck("midreset RXDATA", 8'h10, 32'd0);
    readCheck("midreset CTRL", 8'h0C, 32'd0);

    // Fresh two-byte read afterwards lands in RXDATA[15:0].
    misoWord = 32'hCAFE_0000;
    applyStimulus(8'h03, 24'h000001, 3'd2, 32'h0);
    p0 = pulseCount; c0 = csLowCount;
    regWrite(8'h0C, 32'h1);
    waitDone("read2");
    checkOutput("read2 pulses", pulseCount - p0, 48);
    checkOutput("read2 cs low cycles", csLowCount - c0, 96);
    checkBytes("read2");
    readCheck("read2 RXDATA", 8'h10, 32'h0000_CAFE);
    readCheck("read2 CTRL", 8'h0C, 32'h2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/spi_flash_ip.md
# spi_flash_ip

Memory-mapped SPI flash master controller. A host programs command, flash address, byte count and transmit data through a simple register port, then starts a transaction. The block then runs one SPI mode-0 transfer: command byte, 24-bit address, then 0–4 data bytes read from or written to the flash. It sits between the system register bus and an external serial flash device.

## Interface
- CLK_DIV, default 1: system clocks per spi_clk half-period (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  register write strobe, one cycle.
- rd_en  in  1  register read strobe, one cycle.
- addr  in  8  register byte address.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- spi_cs_n  out  1  flash chip select, active-low.
- spi_clk  out  1  SPI clock, idle low.
- spi_mosi  out  1  serial data to flash.
- spi_miso  in  1  serial data from flash.

## Operation
- Registers (full 8-bit decode; unlisted addresses read 0, writes ignored):
  - 0x00 CMD [7:0] RW.
  - 0x04 FADDR [23:0] RW.
  - 0x08 LEN [2:0] RW; data byte count; values 5–7 act as 4.
  - 0x0C CTRL: write with wdata[0]=1 starts a transaction (ignored while busy). Read returns {30'b0, done, busy}.
  - 0x10 RXDATA RO: received data.
  - 0x14 TXDATA RW [31:0].
- Writes to CMD/FADDR/LEN/TXDATA while busy are accepted but do not affect the running transfer. Fields are latched at start.
- FSM states: IDLE → CMD (8 bits) → ADDR (24 bits, FADDR[23] first) → DATA (8·LEN bits; skipped when LEN=0) → IDLE.
- All fields are shifted MSB first.
- DATA phase direction:
  - Read when latched CMD==0x03: MOSI held 0, and each sampled MISO bit shifts into RXDATA as rx <= {rx[30:0], miso]. RXDATA is cleared to 0 at start, so with LEN=4 the first byte lands in [31:24], and with LEN=1 it lands in [7:0].
  - Any other CMD: transmit TXDATA[8·LEN-1:0] MSB first.
- done is set when a transaction completes and cleared at start.
- Reset state:
  - All registers 0, rdata=0.
  - spi_cs_n=1, spi_clk=0, spi_mosi=0.
  - FSM in IDLE, busy=0, done=0.

## Timing
- Register write takes effect at the clk edge where wr_en=1.
- Read: at the edge where rd_en=1, rdata loads the addressed value and holds until the next read.
- Start on edge N: spi_cs_n=0 and busy=1 from edge N+1, with spi_mosi = first CMD bit.
- SPI mode 0:
  - spi_clk rises CLK_DIV cycles after cs_n falls and toggles every CLK_DIV cycles.
  - MISO is sampled on the system edge that drives spi_clk high.
  - MOSI updates on the edge that drives spi_clk low.
- Bit period is 2·CLK_DIV clocks. Total bits B=32+8·LEN.
- The edge producing the final spi_clk fall also sets spi_cs_n=1, busy=0, done=1 and spi_mosi=0.
- cs_n is low for exactly 2·CLK_DIV·B cycles (CLK_DIV=1, LEN=4: 128 cycles).
- Back-to-back: a new start is accepted the cycle after busy clears.
- Simultaneous wr_en and rd_en to the same address: rdata returns the old value.
- rst asserted mid-transfer: next edge returns to the reset state (cs_n=1, spi_clk=0, registers cleared).

## Test plan
- Reset, then read every register → all 0; spi_cs_n=1, spi_clk=0.
- Write CMD=0x03, FADDR=0x000010, LEN=4, TXDATA=0xAA, then read each → 0x03, 0x10, 0x4, 0xAA.
- CMD=0x03, FADDR=0x10, LEN=4, flash model drives 0xDE,0xAD,0xBE,0xEF on MISO → MOSI carries 0x03,0x00,0x00,0x10; cs_n low for 128 cycles; then RXDATA=0xDEADBEEF and CTRL read=0x2.
- CMD=0x02, FADDR=0x123456, LEN=1, TXDATA=0xAA → MOSI bit stream 0x02,0x12,0x34,0x56,0xAA (40 spi_clk pulses, cs_n low 80 cycles); RXDATA unchanged.
- Start again while busy → ignored; pulse count unchanged. CTRL read mid-transfer → 0x1.
- Assert rst at pulse 20 of a transfer → cs_n=1 and spi_clk=0 next edge, all registers 0; a fresh transfer afterwards completes normally.
